// File: rtl/or_pkg.sv
// ----------------------------------------------------------------------------
// or_pkg
// Shared definitions for the N-input OR/NOR pipeline stage.
//   MODE_NORMAL / MODE_STICKY : values of the per-sample mode input.
//   operand_lsb()             : bit position of operand k inside a packed
//                               operand bus (operand k = [k*WIDTH +: WIDTH]).
// ----------------------------------------------------------------------------
package or_pkg;

    localparam logic MODE_NORMAL = 1'b0;
    localparam logic MODE_STICKY = 1'b1;

    // Every block that slices the packed operand bus goes through this helper,
    // so the packing order is defined in exactly one place.
    function automatic int operand_lsb(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/or_reduce_n.sv
// ----------------------------------------------------------------------------
// or_reduce_n
// Purely combinational bitwise OR of N_IN packed operands.
// Ports:
//   in_data_i [N_IN*WIDTH-1:0]  packed operands, operand k at [k*WIDTH +: WIDTH]
//   r_o       [WIDTH-1:0]       bitwise OR of all operands
// ----------------------------------------------------------------------------
module or_reduce_n
    import or_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int WIDTH = 1
) (
    input  logic [N_IN*WIDTH-1:0] in_data_i,
    output logic [WIDTH-1:0]      r_o
);

    always_comb begin
        r_o = '0;
        for (int k = 0; k < N_IN; k++) begin
            r_o = r_o | in_data_i[operand_lsb(k, WIDTH) +: WIDTH];
        end
    end

endmodule

// File: rtl/nin_or_pipe.sv
// ----------------------------------------------------------------------------
// nin_or_pipe
// Registered N-input OR/NOR flag-merge stage behind a valid/ready handshake,
// with a sticky accumulate mode and a saturating count of non-zero samples.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Upstream: accept = in_valid & in_ready. Downstream: the result is
// consumed when out_valid & out_ready. in_ready = ~out_valid | out_ready is a
// combinational back-pressure path (no skid buffer), so a drain and a new
// accept can share a cycle for one sample per cycle throughput.
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   in_data             packed operands, operand k at [k*WIDTH +: WIDTH]
//   in_valid / in_ready upstream handshake
//   mode                0 = NORMAL, 1 = STICKY, sampled on accept
//   clr                 synchronous clear of sticky accumulator and hit count
//   or_out / nor_out    registered OR result and its inverse
//   out_valid/out_ready downstream handshake
//   hit_cnt             saturating count of accepts whose OR is non-zero
// ----------------------------------------------------------------------------
module nin_or_pipe
    import or_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  mode,
    input  logic                  clr,
    output logic [WIDTH-1:0]      or_out,
    output logic [WIDTH-1:0]      nor_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      hit_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] r;
    logic             accept;

    logic [WIDTH-1:0] or_q,  or_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] hit_q, hit_d;

    // Clear-adjusted views: clr takes effect before a same-cycle sample.
    logic [WIDTH-1:0] acc_base;
    logic [CNT_W-1:0] hit_base;

    or_reduce_n #(
        .N_IN (N_IN),
        .WIDTH(WIDTH)
    ) u_reduce (
        .in_data_i(in_data),
        .r_o      (r)
    );

    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    assign acc_base = clr ? '0 : acc_q;
    assign hit_base = clr ? '0 : hit_q;

    always_comb begin
        or_d        = or_q;
        acc_d       = acc_base;
        hit_d       = hit_base;
        out_valid_d = out_valid_q;

        if (accept) begin
            out_valid_d = 1'b1;
            if (mode == MODE_STICKY) begin
                acc_d = acc_base | r;
                or_d  = acc_base | r;
            end else begin
                or_d  = r;
            end
            // Counted on the raw sample, not on the sticky value.
            if ((r != '0) && (hit_base != CNT_MAX)) begin
                hit_d = hit_base + 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            or_q        <= '0;
            acc_q       <= '0;
            hit_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            or_q        <= or_d;
            acc_q       <= acc_d;
            hit_q       <= hit_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign or_out    = or_q;
    assign nor_out   = ~or_q;
    assign out_valid = out_valid_q;
    assign hit_cnt   = hit_q;

endmodule

// File: tb/tb_nin_or_pipe.sv
// ----------------------------------------------------------------------------
// tb_nin_or_pipe
// Two instances: u_a (N_IN=3, WIDTH=1, CNT_W=8) and u_b (N_IN=4, WIDTH=4,
// CNT_W=2). A transaction-level model predicts every output each cycle; a
// negedge compare process checks both instances against it, and directed
// steps pin specific literal values.
// ----------------------------------------------------------------------------
module tb_nin_or_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // instance A stimulus / outputs
    logic [2:0]  a_data = '0;
    logic        a_valid = 1'b0, a_mode = 1'b0, a_clr = 1'b0, a_ordy = 1'b0;
    logic [0:0]  a_or, a_nor;
    logic        a_ovalid, a_iready;
    logic [7:0]  a_cnt;

    // instance B stimulus / outputs
    logic [15:0] b_data = '0;
    logic        b_valid = 1'b0, b_mode = 1'b0, b_clr = 1'b0, b_ordy = 1'b0;
    logic [3:0]  b_or, b_nor;
    logic        b_ovalid, b_iready;
    logic [1:0]  b_cnt;

    nin_or_pipe #(.N_IN(3), .WIDTH(1), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid),
        .in_ready(a_iready), .mode(a_mode), .clr(a_clr), .or_out(a_or),
        .nor_out(a_nor), .out_valid(a_ovalid), .out_ready(a_ordy), .hit_cnt(a_cnt)
    );

    nin_or_pipe #(.N_IN(4), .WIDTH(4), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid),
        .in_ready(b_iready), .mode(b_mode), .clr(b_clr), .or_out(b_or),
        .nor_out(b_nor), .out_valid(b_ovalid), .out_ready(b_ordy), .hit_cnt(b_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // Per instance: result currently presented, whether it is valid, the
    // accumulated sticky value and the number of non-zero accepted samples.
    logic [3:0] m_or[2];
    logic       m_vld[2];
    logic [3:0] m_acc[2];
    int         m_cnt[2];

    function automatic logic [3:0] or_of(input logic [15:0] data, input int n, input int w);
        logic [3:0] r = '0;
        for (int k = 0; k < n; k++) r = r | 4'((data >> (k * w)) & ((16'd1 << w) - 1));
        return r;
    endfunction

    task automatic model_step(input int i, input logic [15:0] data, input logic vld,
                              input logic md, input logic cl, input logic ordy,
                              input int n, input int w, input int cmax);
        logic [3:0] r, acc;
        int cnt;
        if (!rst_n) begin
            m_or[i] = '0; m_vld[i] = 1'b0; m_acc[i] = '0; m_cnt[i] = 0;
            return;
        end
        r   = or_of(data, n, w);
        acc = cl ? 4'h0 : m_acc[i];
        cnt = cl ? 0 : m_cnt[i];
        if (vld && (!m_vld[i] || ordy)) begin
            if (md) begin
                acc = acc | r;
                m_or[i] = acc;
            end else begin
                m_or[i] = r;
            end
            m_vld[i] = 1'b1;
            if (r != 0 && cnt < cmax) cnt++;
        end else if (ordy) begin
            m_vld[i] = 1'b0;
        end
        m_acc[i] = acc;
        m_cnt[i] = cnt;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_or[i] = '0; m_vld[i] = 1'b0; m_acc[i] = '0; m_cnt[i] = 0;
        end
    end

    always @(posedge clk) begin
        model_step(0, {13'd0, a_data}, a_valid, a_mode, a_clr, a_ordy, 3, 1, 255);
        model_step(1, b_data, b_valid, b_mode, b_clr, b_ordy, 4, 4, 3);
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_or",       {15'd0, a_or},      {15'd0, m_or[0][0]});
            chk("a_nor",      {15'd0, a_nor},     {15'd0, ~m_or[0][0]});
            chk("a_out_valid",{15'd0, a_ovalid},  {15'd0, m_vld[0]});
            chk("a_in_ready", {15'd0, a_iready},  {15'd0, ~m_vld[0] | a_ordy});
            chk("a_hit_cnt",  {8'd0, a_cnt},      16'(m_cnt[0]));
            chk("b_or",       {12'd0, b_or},      {12'd0, m_or[1]});
            chk("b_nor",      {12'd0, b_nor},     {12'd0, ~m_or[1]});
            chk("b_out_valid",{15'd0, b_ovalid},  {15'd0, m_vld[1]});
            chk("b_in_ready", {15'd0, b_iready},  {15'd0, ~m_vld[1] | b_ordy});
            chk("b_hit_cnt",  {14'd0, b_cnt},     16'(m_cnt[1]));
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_b(input logic [15:0] data, input logic vld, input logic md,
                           input logic cl, input logic ordy);
        b_data = data; b_valid = vld; b_mode = md; b_clr = cl; b_ordy = ordy;
    endtask

    logic [1:0] sat_exp[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        tick(); tick();
        rst_n = 1'b1;
        chk_en = 1'b1;
        // reset state
        chk("rst_a_or",        {15'd0, a_or},     16'h0);
        chk("rst_a_nor",       {15'd0, a_nor},    16'h1);
        chk("rst_b_or",        {12'd0, b_or},     16'h0);
        chk("rst_b_nor",       {12'd0, b_nor},    16'hF);
        chk("rst_b_out_valid", {15'd0, b_ovalid}, 16'h0);
        chk("rst_b_in_ready",  {15'd0, b_iready}, 16'h1);
        chk("rst_a_hit_cnt",   {8'd0, a_cnt},     16'h0);

        // truth table on the 3x1 instance
        a_ordy = 1'b1; a_valid = 1'b1; a_mode = 1'b0;
        for (int v = 0; v < 8; v++) begin
            a_data = 3'(v);
            tick();
            chk("tt_or",  {15'd0, a_or},  (v != 0) ? 16'h1 : 16'h0);
            chk("tt_nor", {15'd0, a_nor}, (v != 0) ? 16'h0 : 16'h1);
        end
        a_valid = 1'b0;
        chk("tt_hit_cnt", {8'd0, a_cnt}, 16'd7);
        tick();
        chk("tt_drain_valid", {15'd0, a_ovalid}, 16'h0);

        // NORMAL merge of 0x1,0x2,0x0,0x8
        drive_b(16'h8021, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk("norm_or",  {12'd0, b_or},  16'hB);
        chk("norm_nor", {12'd0, b_nor}, 16'h4);
        chk("norm_cnt", {14'd0, b_cnt}, 16'd1);

        // back-pressure: output held, nothing accepted
        drive_b(16'h0007, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_in_ready", {15'd0, b_iready}, 16'h0);
            chk("bp_or",       {12'd0, b_or},     16'hB);
            chk("bp_cnt",      {14'd0, b_cnt},    16'd1);
        end
        drive_b(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("drain_valid", {15'd0, b_ovalid}, 16'h0);
        chk("drain_or",    {12'd0, b_or},     16'hB);

        // sticky accumulation
        drive_b(16'h0001, 1'b1, 1'b1, 1'b0, 1'b1); tick();
        chk("st1_or", {12'd0, b_or}, 16'h1);
        drive_b(16'h0040, 1'b1, 1'b1, 1'b0, 1'b1); tick();
        chk("st2_or", {12'd0, b_or}, 16'h5);
        drive_b(16'h0000, 1'b1, 1'b1, 1'b0, 1'b1); tick();
        chk("st3_or", {12'd0, b_or}, 16'h5);
        drive_b(16'h0002, 1'b1, 1'b1, 1'b1, 1'b1); tick();
        chk("st_clr_or",  {12'd0, b_or},  16'h2);
        chk("st_clr_cnt", {14'd0, b_cnt}, 16'd1);
        // mode switching keeps acc (=0x2)
        drive_b(16'h0400, 1'b1, 1'b0, 1'b0, 1'b1); tick();
        chk("sw_norm_or", {12'd0, b_or}, 16'h4);
        drive_b(16'h1000, 1'b1, 1'b1, 1'b0, 1'b1); tick();
        chk("sw_sticky_or", {12'd0, b_or}, 16'h3);

        // saturation (CNT_W=2)
        drive_b(16'h0000, 1'b0, 1'b0, 1'b1, 1'b1); tick();
        chk("sat_clr_cnt", {14'd0, b_cnt}, 16'd0);
        for (int s = 0; s < 5; s++) begin
            drive_b(16'h0100 << s, 1'b1, 1'b0, 1'b0, 1'b1); tick();
            chk("sat_cnt", {14'd0, b_cnt}, {14'd0, sat_exp[s]});
        end
        drive_b(16'h0000, 1'b1, 1'b0, 1'b0, 1'b1); tick();
        chk("sat_zero_cnt", {14'd0, b_cnt}, 16'd3);

        // reset mid-operation: acc=0xF, hit_cnt=2, result held
        drive_b(16'h000F, 1'b1, 1'b1, 1'b1, 1'b1); tick();
        drive_b(16'h0030, 1'b1, 1'b1, 1'b0, 1'b1); tick();
        drive_b(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        chk("pre_rst_valid", {15'd0, b_ovalid}, 16'h1);
        chk("pre_rst_or",    {12'd0, b_or},     16'hF);
        chk("pre_rst_cnt",   {14'd0, b_cnt},    16'd2);
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        chk("mid_rst_valid",    {15'd0, b_ovalid}, 16'h0);
        chk("mid_rst_or",       {12'd0, b_or},     16'h0);
        chk("mid_rst_nor",      {12'd0, b_nor},    16'hF);
        chk("mid_rst_cnt",      {14'd0, b_cnt},    16'd0);
        chk("mid_rst_in_ready", {15'd0, b_iready}, 16'h1);
        // acc cleared: sticky zero sample must give 0
        drive_b(16'h0000, 1'b1, 1'b1, 1'b0, 1'b1); tick();
        chk("mid_rst_acc", {12'd0, b_or}, 16'h0);
        drive_b(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1); tick();
        tick();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
